// File: rtl/tuner_lock_seq.sv
// rtl/tuner_lock_seq.sv - search-then-lock sequencer for a ring tuner
// Drives a peak search, locks to a chosen peak, and resumes or re-searches on lock loss.
module tuner_lock_seq #(
  parameter int DAC_WIDTH  = 8,
  parameter int ADC_WIDTH  = 8,
  parameter int NUM_TARGET = 4,
  localparam int SEL_W     = (NUM_TARGET > 1) ? $clog2(NUM_TARGET) : 1,
  localparam int CNT_W     = SEL_W + 1
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst_n,
  input  logic                                 i_start,
  input  logic                                 i_abort,
  input  logic [SEL_W-1:0]                     i_cfg_peak_sel,
  input  logic [3:0]                           i_cfg_retry_max,
  output logic                                 o_search_trig_val,
  input  logic                                 i_search_trig_rdy,
  input  logic                                 i_search_peaks_val,
  output logic                                 o_search_peaks_rdy,
  input  logic [NUM_TARGET-1:0][DAC_WIDTH-1:0] i_search_ring_tune_peaks,
  input  logic [NUM_TARGET-1:0][ADC_WIDTH-1:0] i_search_pwr_peaks,
  input  logic [CNT_W-1:0]                     i_search_peaks_cnt,
  output logic                                 o_lock_trig_val,
  input  logic                                 i_lock_trig_rdy,
  input  logic                                 i_lock_intr_val,
  output logic                                 o_lock_intr_rdy,
  output logic                                 o_lock_resume_val,
  input  logic                                 i_lock_resume_rdy,
  output logic [DAC_WIDTH-1:0]                 o_cfg_ring_tune_peak,
  output logic [ADC_WIDTH-1:0]                 o_cfg_pwr_peak,
  output logic [2:0]                           o_state,
  output logic                                 o_locked,
  output logic                                 o_err,
  output logic [3:0]                           o_retry_cnt,
  output logic [3:0]                           o_intr_cnt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_TRIG = 3'd1,
    S_WAIT = 3'd2,
    L_TRIG = 3'd3,
    LOCKED = 3'd4,
    RESUME = 3'd5,
    ERR    = 3'd6
  } state_t;

  state_t state, next_state;

  logic clr_all, inc_retry, set_err, clr_intr, inc_intr, capture, fail;
  logic peak_valid;
  logic search_trig_val_d, search_peaks_rdy_d, lock_trig_val_d;
  logic lock_intr_rdy_d, lock_resume_val_d, locked_d;

  assign peak_valid = ({1'b0, i_cfg_peak_sel} < i_search_peaks_cnt);
  assign o_state    = state;

  // Handshake outputs are flops loaded from next_state, so they carry no input-to-output path.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                <= IDLE;
      o_search_trig_val    <= 1'b0;
      o_search_peaks_rdy   <= 1'b0;
      o_lock_trig_val      <= 1'b0;
      o_lock_intr_rdy      <= 1'b0;
      o_lock_resume_val    <= 1'b0;
      o_locked             <= 1'b0;
      o_err                <= 1'b0;
      o_retry_cnt          <= 4'd0;
      o_intr_cnt           <= 4'd0;
      o_cfg_ring_tune_peak <= '0;
      o_cfg_pwr_peak       <= '0;
    end else begin
      state              <= next_state;
      o_search_trig_val  <= search_trig_val_d;
      o_search_peaks_rdy <= search_peaks_rdy_d;
      o_lock_trig_val    <= lock_trig_val_d;
      o_lock_intr_rdy    <= lock_intr_rdy_d;
      o_lock_resume_val  <= lock_resume_val_d;
      o_locked           <= locked_d;
      if (clr_all) begin
        o_retry_cnt <= 4'd0;
        o_intr_cnt  <= 4'd0;
        o_err       <= 1'b0;
      end
      if (inc_retry) o_retry_cnt <= o_retry_cnt + 4'd1;
      if (set_err) o_err <= 1'b1;
      if (clr_intr) o_intr_cnt <= 4'd0;
      if (inc_intr && (o_intr_cnt != 4'hf)) o_intr_cnt <= o_intr_cnt + 4'd1;
      if (capture) begin
        o_cfg_ring_tune_peak <= i_search_ring_tune_peaks[i_cfg_peak_sel];
        o_cfg_pwr_peak       <= i_search_pwr_peaks[i_cfg_peak_sel];
      end
    end
  end

  always_comb begin
    next_state = state;
    clr_all    = 1'b0;
    inc_retry  = 1'b0;
    set_err    = 1'b0;
    clr_intr   = 1'b0;
    inc_intr   = 1'b0;
    capture    = 1'b0;
    fail       = 1'b0;
    case (state)
      IDLE, ERR: begin
        if (i_start) begin
          clr_all    = 1'b1;
          next_state = S_TRIG;
        end
      end
      S_TRIG: if (i_search_trig_rdy) next_state = S_WAIT;
      S_WAIT: begin
        if (i_search_peaks_val) begin
          if (peak_valid) begin
            capture    = 1'b1;
            next_state = L_TRIG;
          end else begin
            fail = 1'b1;
          end
        end
      end
      L_TRIG: begin
        if (i_lock_trig_rdy) begin
          clr_intr   = 1'b1;
          next_state = LOCKED;
        end
      end
      LOCKED: begin
        if (i_lock_intr_val) begin
          inc_intr = 1'b1;
          if (o_intr_cnt < i_cfg_retry_max) next_state = RESUME;
          else fail = 1'b1;
        end
      end
      RESUME: if (i_lock_resume_rdy) next_state = LOCKED;
      default: next_state = IDLE;
    endcase
    // A failed search spends one retry, or ends in ERR once the budget is used up.
    if (fail) begin
      if (o_retry_cnt < i_cfg_retry_max) begin
        inc_retry  = 1'b1;
        next_state = S_TRIG;
      end else begin
        set_err    = 1'b1;
        next_state = ERR;
      end
    end
    if (i_abort) begin
      next_state = IDLE;
      clr_all    = 1'b0;
      inc_retry  = 1'b0;
      set_err    = 1'b0;
      clr_intr   = 1'b0;
      inc_intr   = 1'b0;
      capture    = 1'b0;
    end
  end

  always_comb begin
    search_trig_val_d  = (next_state == S_TRIG);
    search_peaks_rdy_d = (next_state == S_WAIT);
    lock_trig_val_d    = (next_state == L_TRIG);
    lock_intr_rdy_d    = (next_state == LOCKED);
    lock_resume_val_d  = (next_state == RESUME);
    locked_d           = (next_state == LOCKED);
  end

endmodule

// File: doc/tuner_lock_seq.md
TUNER_LOCK_SEQ -- requirements
Module: tuner_lock_seq

Interface
REQ-001 Parameters SHALL be: DAC_WIDTH, default 8, ring tune code width; ADC_WIDTH, default 8, power code width; NUM_TARGET, default 4, peak slots per search.
REQ-002 Ports SHALL be:
- i_clk  in  1  sole clock; all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  single-cycle pulse; begins the search-then-lock sequence.
- i_abort  in  1  level; forces IDLE.
- i_cfg_peak_sel  in  $clog2(NUM_TARGET)  index of the peak slot to lock to.
- i_cfg_retry_max  in  4  maximum re-search attempts; also the resume budget.
- o_search_trig_val  out  1  search request.
- i_search_trig_rdy  in  1  search engine accepts request.
- i_search_peaks_val  in  1  peak results valid.
- o_search_peaks_rdy  out  1  results accepted.
- i_search_ring_tune_peaks  in  [NUM_TARGET][DAC_WIDTH]  tune code per peak.
- i_search_pwr_peaks  in  [NUM_TARGET][ADC_WIDTH]  power per peak.
- i_search_peaks_cnt  in  $clog2(NUM_TARGET)+1  number of valid peaks.
- o_lock_trig_val  out  1  lock request.
- i_lock_trig_rdy  in  1  lock engine accepts request.
- i_lock_intr_val  in  1  lock-loss interrupt.
- o_lock_intr_rdy  out  1  interrupt acknowledged.
- o_lock_resume_val  out  1  resume request.
- i_lock_resume_rdy  in  1  resume accepted.
- o_cfg_ring_tune_peak  out  DAC_WIDTH  registered lock target tune code.
- o_cfg_pwr_peak  out  ADC_WIDTH  registered lock target power.
- o_state  out  3  FSM state encoding.
- o_locked  out  1  high in LOCKED.
- o_err  out  1  sticky error flag.
- o_retry_cnt  out  4  re-searches since i_start.
- o_intr_cnt  out  4  interrupts since the last lock trigger.

Function
REQ-003 States SHALL be IDLE=0, S_TRIG=1, S_WAIT=2, L_TRIG=3, LOCKED=4, RESUME=5, ERR=6.
REQ-004 IDLE: on i_start, clear o_retry_cnt, o_intr_cnt, o_err; go to S_TRIG next cycle.
REQ-005 S_TRIG: o_search_trig_val=1; on i_search_trig_rdy, go to S_WAIT.
REQ-006 S_WAIT: o_search_peaks_rdy=1; on i_search_peaks_val, capture the slot selected by i_cfg_peak_sel into o_cfg_ring_tune_peak/o_cfg_pwr_peak in the same edge.
REQ-007 In S_WAIT, valid results (i_cfg_peak_sel < i_search_peaks_cnt) SHALL go to L_TRIG; otherwise (count 0 or index out of range) they SHALL be a failed search under REQ-011 and leave the cfg outputs unchanged.
REQ-008 L_TRIG: o_lock_trig_val=1, cfg outputs stable; on i_lock_trig_rdy, clear o_intr_cnt and go to LOCKED.
REQ-009 LOCKED: o_lock_intr_rdy=1, o_locked=1; on i_lock_intr_val, increment o_intr_cnt (saturating at 15).
REQ-010 On an interrupt in LOCKED, the pre-increment o_intr_cnt < i_cfg_retry_max SHALL go to RESUME; otherwise it SHALL be a failed search under REQ-011.
REQ-011 Failed search: if o_retry_cnt < i_cfg_retry_max, increment o_retry_cnt and go to S_TRIG; else set o_err and go to ERR.
REQ-012 RESUME: o_lock_resume_val=1; on i_lock_resume_rdy, return to LOCKED.
REQ-013 ERR SHALL hold until i_start, which acts as in IDLE.
REQ-014 Every val output SHALL stay high until its rdy is sampled high, and SHALL be registered, with no combinational path from an input to it.
REQ-015 i_abort SHALL have priority over all transitions: next state IDLE, all val/rdy outputs low next cycle, counters and cfg outputs held.
REQ-016 i_start outside IDLE/ERR SHALL be ignored.
REQ-017 i_cfg_retry_max=0: the first failed search or interrupt SHALL go directly to ERR.

Reset
REQ-018 While i_rst_n=0: state IDLE, all handshake outputs 0, o_cfg_* 0, counters 0, o_locked 0, o_err 0; deassertion takes effect at the next i_clk edge.
REQ-019 Reset asserted mid-handshake SHALL drop val/rdy immediately, asynchronously, without waiting for the clock.

Verification
REQ-020 Nominal: retry_max=2, sel=1, peaks_cnt=2, tune={40,90}, pwr={200,180} -> o_cfg_ring_tune_peak=90, o_cfg_pwr_peak=180, L_TRIG, LOCKED, o_locked=1, o_retry_cnt=0.
REQ-021 Interrupts: retry_max=2, three interrupts in LOCKED -> RESUME twice, then the third re-searches with o_retry_cnt=1 and o_intr_cnt=3.
REQ-022 Empty search: peaks_cnt=0 on every search, retry_max=3 -> four searches, then ERR, o_err=1, o_retry_cnt=3.
REQ-023 Backpressure: trig_rdy low for 10 cycles -> o_search_trig_val held high for all 10 cycles; exactly one transfer.
REQ-024 Abort and reset: i_abort during S_WAIT -> IDLE next cycle, o_search_peaks_rdy=0; i_rst_n low in RESUME -> o_lock_resume_val=0 immediately and all outputs at reset values.
